// File: rtl/mask_stream_tx.sv
// mask_stream_tx: double-buffered 1-bit mask store replayed as a raster pixel stream.
// Define MASK_TX_BBOX_EN to add per-frame bounding-box outputs.
module mask_stream_tx #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 180
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [8:0] pix_x_in,
   input  logic [7:0] pix_y_in,
   input  logic       pix_mask_in,
   input  logic       pix_valid_in,
   input  logic       frame_done_in,
   input  logic       ready_in,
   output logic [8:0] x_out,
   output logic [7:0] y_out,
   output logic       mask_out,
   output logic       valid_out,
   output logic       new_frame_out,
   output logic       busy_out,
   output logic       drop_out
`ifdef MASK_TX_BBOX_EN
   ,
   output logic [8:0] bbox_x_min_out,
   output logic [8:0] bbox_x_max_out,
   output logic [7:0] bbox_y_min_out,
   output logic [7:0] bbox_y_max_out,
   output logic       bbox_valid_out
`endif
);
   localparam int WORD_W = 64;
   localparam int WPR    = (WIDTH + WORD_W - 1) / WORD_W;
   localparam int DEPTH  = WPR * HEIGHT;
   localparam int AW     = $clog2(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state;
   logic              wr;
   logic              rd_full;
   logic              primed;
   logic [AW-1:0]     wa;
   logic [AW-1:0]     fa;
   logic [AW-1:0]     fa_n;
   logic [WORD_W-1:0] mem [2][DEPTH];
   logic [WORD_W-1:0] rd_data;
   logic [WORD_W-1:0] cur;
   logic              wr_ok;
   logic              accept;
   logic              step;
   logic              last;
   logic              word_end;
   logic [5:0]        nb;

   assign wr_ok = pix_valid_in
                  && (pix_x_in < 9'(WIDTH))
                  && (pix_y_in < 8'(HEIGHT));
   assign wa = AW'(pix_y_in) * AW'(WPR) + AW'(pix_x_in[8:6]);

   assign accept   = frame_done_in && (state == IDLE || state == DONE);
   assign step     = (state == SEND) && valid_out && ready_in;
   assign last     = (x_out == 9'(WIDTH-1)) && (y_out == 8'(HEIGHT-1));
   assign word_end = (&x_out[5:0]) || (x_out == 9'(WIDTH-1));
   assign nb       = x_out[5:0] + 6'd1;
   assign busy_out = (state == FETCH) || (state == SEND);

   // rd_data always holds the word after cur, so a word switch never stalls
   always_comb begin
      fa_n = fa;
      if (state == FETCH && rd_full)
         fa_n = primed ? AW'(1) : '0;
      else if (step && word_end && fa != AW'(DEPTH-1))
         fa_n = fa + AW'(1);
   end

   always_ff @(posedge clk_in) begin
      if (wr_ok)
         mem[wr][wa][pix_x_in[5:0]] <= pix_mask_in;
      rd_data <= mem[~wr][fa_n];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state         <= IDLE;
         wr            <= 1'b0;
         rd_full       <= 1'b0;
         primed        <= 1'b0;
         fa            <= '0;
         cur           <= '0;
         x_out         <= '0;
         y_out         <= '0;
         mask_out      <= 1'b0;
         valid_out     <= 1'b0;
         new_frame_out <= 1'b0;
         drop_out      <= 1'b0;
      end else begin
         new_frame_out <= 1'b0;
         drop_out      <= frame_done_in && !accept;
         fa            <= fa_n;
         unique case (state)
            IDLE: ;
            FETCH: begin
               if (rd_full) begin
                  if (!primed) begin
                     primed <= 1'b1;
                  end else begin
                     primed    <= 1'b0;
                     cur       <= rd_data;
                     x_out     <= '0;
                     y_out     <= '0;
                     mask_out  <= rd_data[0];
                     valid_out <= 1'b1;
                     state     <= SEND;
                  end
               end
            end
            SEND: begin
               if (step) begin
                  if (last) begin
                     valid_out     <= 1'b0;
                     new_frame_out <= 1'b1;
                     rd_full       <= 1'b0;
                     state         <= DONE;
                  end else begin
                     if (x_out == 9'(WIDTH-1)) begin
                        x_out <= '0;
                        y_out <= y_out + 8'd1;
                     end else begin
                        x_out <= x_out + 9'd1;
                     end
                     if (word_end) begin
                        cur      <= rd_data;
                        mask_out <= rd_data[0];
                     end else begin
                        mask_out <= cur[nb];
                     end
                  end
               end
            end
            DONE: state <= IDLE;
         endcase
         if (accept) begin
            state   <= FETCH;
            wr      <= ~wr;
            rd_full <= 1'b1;
         end
      end
   end

`ifdef MASK_TX_BBOX_EN
   logic [8:0] bx_lo, bx_hi, nx_lo, nx_hi;
   logic [7:0] by_lo, by_hi, ny_lo, ny_hi;
   logic       bany, nany;

   always_comb begin
      nx_lo = bx_lo;
      nx_hi = bx_hi;
      ny_lo = by_lo;
      ny_hi = by_hi;
      nany  = bany;
      if (step && mask_out) begin
         if (x_out < bx_lo) nx_lo = x_out;
         if (x_out > bx_hi) nx_hi = x_out;
         if (y_out < by_lo) ny_lo = y_out;
         if (y_out > by_hi) ny_hi = y_out;
         nany = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         bx_lo          <= '1;
         bx_hi          <= '0;
         by_lo          <= '1;
         by_hi          <= '0;
         bany           <= 1'b0;
         bbox_x_min_out <= '0;
         bbox_x_max_out <= '0;
         bbox_y_min_out <= '0;
         bbox_y_max_out <= '0;
         bbox_valid_out <= 1'b0;
      end else begin
         if (state == FETCH) begin
            bx_lo <= '1;
            bx_hi <= '0;
            by_lo <= '1;
            by_hi <= '0;
            bany  <= 1'b0;
         end else begin
            bx_lo <= nx_lo;
            bx_hi <= nx_hi;
            by_lo <= ny_lo;
            by_hi <= ny_hi;
            bany  <= nany;
         end
         if (step && last) begin
            bbox_x_min_out <= nx_lo;
            bbox_x_max_out <= nx_hi;
            bbox_y_min_out <= ny_lo;
            bbox_y_max_out <= ny_hi;
            bbox_valid_out <= nany;
         end
      end
   end
`endif

endmodule
